// File: rtl/gf2m_pkg.sv
// Shared GF(2^163) constants for the ECC datapath (multiplier and divider).
package gf2m_pkg;

    localparam int M     = 163;
    localparam int CNT_W = 10;

    // Low-order terms of f(x) = x^163 + x^7 + x^6 + x^3 + 1; x^M is implicit.
    localparam logic [M-1:0] POLY = 163'h00C9;

    // Full modulus including the implicit x^M term.
    localparam logic [M:0] F = {1'b1, POLY};

    // Divider sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/gf2m_div_x.sv
// Combinational division by x modulo f: q = g / x mod f.
// An odd g is made even by adding f first. f has bit M set, so after the
// shift the top bit of q is set and q still fits in M bits.
module gf2m_div_x
    import gf2m_pkg::*;
#(
    parameter int          W    = M,
    parameter logic [W-1:0] P   = POLY
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] q
);

    // Halve g, folding in the modulus when g is odd.
    always_comb begin
        q = {1'b0, g[W-1:1]};
        if (g[0]) begin
            q = {1'b1, g[W-1:1] ^ P[W-1:1]};
        end else begin
            q = {1'b0, g[W-1:1]};
        end
    end

endmodule

// File: rtl/gf2m_binary_divider.sv
// Sequential GF(2^163) modular divider Z = A / B mod f using the binary
// extended Euclidean algorithm. One reduction step per RUN cycle, with an
// iteration counter that forces an error exit if the loop ever runs away.
module gf2m_binary_divider
    import gf2m_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic [M-1:0] Z,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int DEG_W = $clog2(M + 1);

    localparam logic [M:0]       ONE       = {{M{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(4 * M + 4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_t       state;
    logic [M:0]       u;
    logic [M:0]       v;
    logic [M-1:0]     g1;
    logic [M-1:0]     g2;
    logic [CNT_W-1:0] cnt;

    logic [M-1:0]     g1_div;
    logic [M-1:0]     g2_div;
    logic             u_is_one;
    logic             v_is_one;
    logic             u_deg_gt;

    // Index of the most-significant set bit (0 when x is 0).
    function automatic logic [DEG_W-1:0] deg_of(input logic [M:0] x);
        logic [DEG_W-1:0] d;
        d = '0;
        for (int i = 0; i <= M; i++) begin
            d = x[i] ? DEG_W'(i) : d;
        end
        return d;
    endfunction

    gf2m_div_x #(.W(M), .P(POLY)) u_div_g1 (
        .g (g1),
        .q (g1_div)
    );

    gf2m_div_x #(.W(M), .P(POLY)) u_div_g2 (
        .g (g2),
        .q (g2_div)
    );

    // Step-selection predicates for the current u, v pair.
    always_comb begin
        u_is_one = (u == ONE);
        v_is_one = (v == ONE);
        u_deg_gt = (deg_of(u) > deg_of(v));
    end

    // Control FSM plus operand datapath; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            u     <= '0;
            v     <= '0;
            g1    <= '0;
            g2    <= '0;
            cnt   <= '0;
            Z     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        u   <= {1'b0, B};
                        v   <= F;
                        g1  <= A;
                        g2  <= '0;
                        cnt <= '0;
                        err <= 1'b0;
                        if (B == '0) begin
                            // Division by zero: report immediately.
                            err   <= 1'b1;
                            Z     <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LIMIT) begin
                        // Loop never converged: safety exit.
                        err   <= 1'b1;
                        Z     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (u_is_one) begin
                        Z     <= g1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (v_is_one) begin
                        Z     <= g2;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        g1 <= g1_div;
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        g2 <= g2_div;
                    end else if (u_deg_gt) begin
                        u  <= u ^ v;
                        g1 <= g1 ^ g2;
                    end else begin
                        v  <= v ^ u;
                        g2 <= g2 ^ g1;
                    end
                end

                FIN: begin
                    // Single-cycle result strobe; operands are left as-is.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_binary_divider.sv
// Directed and randomised checks for the GF(2^163) binary divider.
module tb_gf2m_binary_divider;

    localparam int          MW      = 163;
    localparam int          MAX_LAT = 4 * MW + 6;
    localparam logic [MW-1:0] POLY_L = 163'h00C9;

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] z;
        logic          e;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [MW-1:0] dut_a;
    logic [MW-1:0] dut_b;
    logic [MW-1:0] dut_z;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks;
    int n_fail;

    gf2m_binary_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (dut_a),
        .B     (dut_b),
        .Z     (dut_z),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference multiplier: shift-and-add with reduction by f.
    function automatic logic [MW-1:0] gf_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        r = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (r[MW-1]) r = (r << 1) ^ POLY_L;
            else         r = r << 1;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rand163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[MW-1:0];
    endfunction

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one division and wait (bounded) for its done pulse.
    task automatic run_op(input logic [MW-1:0] a_in, input logic [MW-1:0] b_in, input bit inject,
                          output logic [MW-1:0] z_out, output logic err_out, output int lat,
                          output bit timed_out, output bit overlap, output logic busy_first);
        @(negedge clk);
        dut_a = a_in;
        dut_b = b_in;
        start = 1'b1;
        lat = 0;
        timed_out = 1'b0;
        overlap = 1'b0;
        busy_first = 1'b0;
        z_out = '0;
        err_out = 1'b0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy_first = busy;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                z_out = dut_z;
                err_out = err;
                start = 1'b0;
                break;
            end
            if (lat >= MAX_LAT + 40) begin
                timed_out = 1'b1;
                start = 1'b0;
                break;
            end
            if (inject && (lat % 5 == 2)) begin
                start = 1'b1;
                dut_a = rand163();
                dut_b = rand163();
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        vec_t          vecs[10];
        logic [MW-1:0] x162;
        logic [MW-1:0] z;
        logic [MW-1:0] a_r;
        logic [MW-1:0] b_r;
        logic          e;
        logic          bf;
        int            lat;
        bit            to;
        bit            ov;
        bit            seen_done;

        n_checks = 0;
        n_fail   = 0;
        x162 = '0;
        x162[MW-1] = 1'b1;

        vecs[0] = '{a: 163'hABCD, b: 163'h1,   z: 163'hABCD, e: 1'b0};
        vecs[1] = '{a: 163'h20,   b: 163'h2,   z: 163'h10,   e: 1'b0};
        vecs[2] = '{a: 163'h1,    b: 163'h2,   z: x162 | 163'h64, e: 1'b0};
        vecs[3] = '{a: 163'h1234, b: 163'h0,   z: 163'h0,    e: 1'b1};
        vecs[4] = '{a: 163'h5A5A, b: 163'h1,   z: 163'h5A5A, e: 1'b0};
        vecs[5] = '{a: 163'h0,    b: 163'h5,   z: 163'h0,    e: 1'b0};
        vecs[6] = '{a: 163'h6,    b: 163'h3,   z: 163'h2,    e: 1'b0};
        vecs[7] = '{a: 163'hC9,   b: x162,     z: 163'h2,    e: 1'b0};
        vecs[8] = '{a: x162,      b: x162,     z: 163'h1,    e: 1'b0};
        vecs[9] = '{a: 163'h8F3,  b: 163'h8F3, z: 163'h1,    e: 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        dut_a = '0;
        dut_b = '0;
        #1;
        check("reset_z",    dut_z, '0);
        check("reset_busy", {162'd0, busy}, '0);
        check("reset_done", {162'd0, done}, '0);
        check("reset_err",  {162'd0, err},  '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, z, e, lat, to, ov, bf);
            check($sformatf("vec%0d_timeout", i), {162'd0, to}, '0);
            check($sformatf("vec%0d_z", i), z, vecs[i].z);
            check($sformatf("vec%0d_err", i), {162'd0, e}, {162'd0, vecs[i].e});
            check($sformatf("vec%0d_busy_after_start", i), {162'd0, bf}, {162'd0, (vecs[i].b != '0)});
            check($sformatf("vec%0d_overlap", i), {162'd0, ov}, '0);
            if (vecs[i].b == 163'h1)
                check($sformatf("vec%0d_latency", i), MW'(lat), MW'(2));
            else if (vecs[i].b == '0)
                check($sformatf("vec%0d_latency", i), MW'(lat), MW'(1));
            else
                check($sformatf("vec%0d_latency_bound", i), {162'd0, (lat <= MAX_LAT)}, 163'h1);
        end

        // Random operands with stray start pulses while busy.
        for (int k = 0; k < 100; k++) begin
            a_r = rand163();
            b_r = rand163();
            if (b_r == '0) b_r = 163'h1;
            run_op(a_r, b_r, 1'b1, z, e, lat, to, ov, bf);
            check($sformatf("rnd%0d_product", k), gf_mul(z, b_r), a_r);
            check($sformatf("rnd%0d_err", k), {162'd0, e}, '0);
            check($sformatf("rnd%0d_latency_bound", k), {162'd0, (!to && lat <= MAX_LAT)}, 163'h1);
            check($sformatf("rnd%0d_overlap", k), {162'd0, ov}, '0);
        end

        // Reset in the middle of a long run.
        run_op(163'h20, 163'h2, 1'b0, z, e, lat, to, ov, bf);
        check("pre_reset_z", z, 163'h10);
        @(negedge clk);
        dut_a = rand163();
        dut_b = x162;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("mid_run_busy", {162'd0, busy}, 163'h1);
        rst = 1'b1;
        #1;
        check("abort_z",    dut_z, '0);
        check("abort_busy", {162'd0, busy}, '0);
        check("abort_done", {162'd0, done}, '0);
        check("abort_err",  {162'd0, err},  '0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("no_done_after_abort", {162'd0, seen_done}, '0);
        run_op(163'h6, 163'h3, 1'b0, z, e, lat, to, ov, bf);
        check("post_reset_z", z, 163'h2);
        check("post_reset_err", {162'd0, e}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
